// File: rtl/round_key_gen_pkg.sv
// Shared definitions for the Pelican round-key schedule: widths, FSM states
// and the 6-bit round-constant LFSR step functions (forward and inverse).
package round_key_gen_pkg;

   localparam int RC_W   = 6;
   localparam int WORD_W = 32;
   localparam int KEY_W  = 4 * WORD_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      EMIT = 2'd2
   } rk_state_t;

   // Forward LFSR step: shift left, feed back the complemented XOR of the two top bits.
   function automatic logic [RC_W-1:0] rc_fwd(input logic [RC_W-1:0] r);
      return {r[4:0], ~(r[5] ^ r[4])};
   endfunction

   // Exact inverse of rc_fwd: recover the bit shifted out of the top.
   function automatic logic [RC_W-1:0] rc_inv(input logic [RC_W-1:0] r);
      return {~(r[0] ^ r[5]), r[5:1]};
   endfunction

endpackage

// File: rtl/round_key_gen_rk_step.sv
// Combinational single step of the key schedule state (k0..k3 and rc).
// dir=0 advances one round, dir=1 undoes one round exactly.
module rk_step
   import round_key_gen_pkg::*;
#(
   parameter int ROT = 8
) (
   input  logic             dir,
   input  logic [KEY_W-1:0] key_cur,
   input  logic [RC_W-1:0]  rc_cur,
   output logic [KEY_W-1:0] key_nxt,
   output logic [RC_W-1:0]  rc_nxt
);

   localparam int R = ROT % WORD_W;

   logic [WORD_W-1:0] k0, k1, k2, k3;

   assign {k0, k1, k2, k3} = key_cur;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x);
      if (R == 0) return x;
      return (x << R) | (x >> (WORD_W - R));
   endfunction

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x);
      if (R == 0) return x;
      return (x >> R) | (x << (WORD_W - R));
   endfunction

   // Forward step by default; reverse step rotates the recycled word back into k0.
   always_comb begin
      key_nxt = {k1, k2, k3, rotl(k0)};
      rc_nxt  = rc_fwd(rc_cur);
      if (dir) begin
         key_nxt = {rotr(k3), k0, k1, k2};
         rc_nxt  = rc_inv(rc_cur);
      end
   end

endmodule

// File: rtl/round_key_gen.sv
// Sequential producer of per-round (key0, key2, rc) beats over a valid/ready
// handshake. Forward mode emits rounds 0..N-1; decrypt mode first runs the
// schedule forward to round N-1 internally, then emits rounds N-1..0.
module round_key_gen
   import round_key_gen_pkg::*;
#(
   parameter int              NUM_ROUNDS = 32,
   parameter logic [RC_W-1:0] RC_INIT    = 6'h01,
   parameter int              ROT        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              decrypt,
   input  logic [KEY_W-1:0]  key_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] key0,
   output logic [WORD_W-1:0] key2,
   output logic [RC_W-1:0]   rc,
   output logic              last,
   output logic              busy
);

   localparam logic [5:0] LAST_CNT = 6'(NUM_ROUNDS - 1);
   localparam logic [5:0] PREP_END = 6'(NUM_ROUNDS - 2);

   rk_state_t        state, state_nxt;
   logic [5:0]       cnt;
   logic             dir;
   logic [KEY_W-1:0] key_r, key_nxt;
   logic [RC_W-1:0]  rc_r, rc_nxt;
   logic             step_dir;
   logic             hs;

   assign out_valid = (state == EMIT);
   assign last      = (state == EMIT) && (cnt == LAST_CNT);
   assign busy      = (state != IDLE);
   assign hs        = out_valid & out_ready;
   assign key0      = key_r[KEY_W-1 -: WORD_W];
   assign key2      = key_r[2*WORD_W-1 -: WORD_W];
   assign rc        = rc_r;

   // Fast-forward in PREP is always a forward step; EMIT follows the latched direction.
   assign step_dir  = (state == EMIT) & dir;

   rk_step #(.ROT(ROT)) u_step (
      .dir     (step_dir),
      .key_cur (key_r),
      .rc_cur  (rc_r),
      .key_nxt (key_nxt),
      .rc_nxt  (rc_nxt)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: start only matters in IDLE, so it never restarts a running schedule.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = decrypt ? PREP : EMIT;
         PREP:    if (cnt == PREP_END) state_nxt = EMIT;
         EMIT:    if (hs && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Key/rc registers and round counter; PREP steps every cycle, EMIT steps per accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r <= '0;
         rc_r  <= '0;
         cnt   <= '0;
         dir   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  key_r <= key_in;
                  rc_r  <= RC_INIT;
                  cnt   <= '0;
                  dir   <= decrypt;
               end
            end
            PREP: begin
               key_r <= key_nxt;
               rc_r  <= rc_nxt;
               cnt   <= (cnt == PREP_END) ? 6'd0 : cnt + 6'd1;
            end
            EMIT: begin
               if (hs) begin
                  key_r <= key_nxt;
                  rc_r  <= rc_nxt;
                  cnt   <= cnt + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
